// File: rtl/fwd_hazard_ctrl.sv
// Forward-select and D-stage stall generation for the 5-stage pipeline.
// Optional MDU_STALL_EN adds md_busy/d_is_md so HI/LO users stall while the MDU is busy.
module fwd_hazard_ctrl #(
    parameter logic [1:0] TUSE_NONE = 2'd3
) (
    input  logic       clk,
    input  logic       reset,
`ifdef MDU_STALL_EN
    input  logic       md_busy,
    input  logic       d_is_md,
`endif
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic       d_we,
    input  logic [1:0] d_tnew,
    output logic       stall,
    output logic [2:0] frsd,
    output logic [2:0] frtd,
    output logic [2:0] frse,
    output logic [2:0] frte,
    output logic [2:0] frtm
);

    logic [4:0] e_a3_q, e_a3_d;
    logic [1:0] e_tnew_q, e_tnew_d;
    logic [4:0] m_a3_q, m_a3_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_a3_q, w_a3_d;
    logic [1:0] w_tnew_q, w_tnew_d;
    logic [4:0] rs_e_q, rs_e_d;
    logic [4:0] rt_e_q, rt_e_d;
    logic [4:0] rt_m_q, rt_m_d;

    logic hz_rs, hz_rt, hz_md;

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A producer is forwardable only once its result exists (tnew == 0).
    function automatic logic fwd_hit(input logic [4:0] a3,
                                     input logic [1:0] tnew,
                                     input logic [4:0] r);
        return (r != 5'd0) && (a3 == r) && (tnew == 2'd0);
    endfunction

    function automatic logic too_late(input logic [4:0] a3,
                                      input logic [1:0] tnew,
                                      input logic [4:0] r,
                                      input logic [1:0] tuse);
        return (r != 5'd0) && (a3 == r) && (tnew > tuse);
    endfunction

    always_comb begin
        hz_rs = 1'b0;
        hz_rt = 1'b0;
        if (d_tuse_rs != TUSE_NONE) begin
            hz_rs = too_late(e_a3_q, e_tnew_q, d_rs, d_tuse_rs) ||
                    too_late(m_a3_q, m_tnew_q, d_rs, d_tuse_rs);
        end
        if (d_tuse_rt != TUSE_NONE) begin
            hz_rt = too_late(e_a3_q, e_tnew_q, d_rt, d_tuse_rt) ||
                    too_late(m_a3_q, m_tnew_q, d_rt, d_tuse_rt);
        end
`ifdef MDU_STALL_EN
        hz_md = md_busy && d_is_md;
`else
        hz_md = 1'b0;
`endif
        stall = hz_rs || hz_rt || hz_md;
    end

    always_comb begin
        frsd = 3'd0;
        if (d_tuse_rs != TUSE_NONE) begin
            if (fwd_hit(e_a3_q, e_tnew_q, d_rs))      frsd = 3'd1;
            else if (fwd_hit(m_a3_q, m_tnew_q, d_rs)) frsd = 3'd2;
            else if (fwd_hit(w_a3_q, w_tnew_q, d_rs)) frsd = 3'd3;
        end
        frtd = 3'd0;
        if (d_tuse_rt != TUSE_NONE) begin
            if (fwd_hit(e_a3_q, e_tnew_q, d_rt))      frtd = 3'd1;
            else if (fwd_hit(m_a3_q, m_tnew_q, d_rt)) frtd = 3'd2;
            else if (fwd_hit(w_a3_q, w_tnew_q, d_rt)) frtd = 3'd3;
        end
        frse = 3'd0;
        if (fwd_hit(m_a3_q, m_tnew_q, rs_e_q))      frse = 3'd1;
        else if (fwd_hit(w_a3_q, w_tnew_q, rs_e_q)) frse = 3'd2;
        frte = 3'd0;
        if (fwd_hit(m_a3_q, m_tnew_q, rt_e_q))      frte = 3'd1;
        else if (fwd_hit(w_a3_q, w_tnew_q, rt_e_q)) frte = 3'd2;
        frtm = 3'd0;
        if (fwd_hit(w_a3_q, w_tnew_q, rt_m_q))      frtm = 3'd1;
    end

    // On stall the E slot takes a bubble, which matches the reset state.
    always_comb begin
        if (stall) begin
            e_a3_d   = 5'd0;
            e_tnew_d = 2'd0;
            rs_e_d   = 5'd0;
            rt_e_d   = 5'd0;
        end else begin
            e_a3_d   = d_we ? d_a3 : 5'd0;
            e_tnew_d = d_tnew;
            rs_e_d   = d_rs;
            rt_e_d   = d_rt;
        end
        m_a3_d   = e_a3_q;
        m_tnew_d = dec_sat(e_tnew_q);
        rt_m_d   = rt_e_q;
        w_a3_d   = m_a3_q;
        w_tnew_d = dec_sat(m_tnew_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_a3_q   <= 5'd0;
            e_tnew_q <= 2'd0;
            m_a3_q   <= 5'd0;
            m_tnew_q <= 2'd0;
            w_a3_q   <= 5'd0;
            w_tnew_q <= 2'd0;
            rs_e_q   <= 5'd0;
            rt_e_q   <= 5'd0;
            rt_m_q   <= 5'd0;
        end else begin
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            w_a3_q   <= w_a3_d;
            w_tnew_q <= w_tnew_d;
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            rt_m_q   <= rt_m_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl.
// Define MDU_STALL_EN to also exercise the MDU busy stall.
module tb_fwd_hazard_ctrl;

    localparam logic [1:0] NONE = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       md_busy;
    logic       d_is_md;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_we;
    logic       stall;
    logic [2:0] frsd, frtd, frse, frte, frtm;

    int total = 0;
    int bad   = 0;

    fwd_hazard_ctrl dut (
        .clk      (clk),
        .reset    (reset),
`ifdef MDU_STALL_EN
        .md_busy  (md_busy),
        .d_is_md  (d_is_md),
`endif
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_tuse_rs(d_tuse_rs),
        .d_tuse_rt(d_tuse_rt),
        .d_a3     (d_a3),
        .d_we     (d_we),
        .d_tnew   (d_tnew),
        .stall    (stall),
        .frsd     (frsd),
        .frtd     (frtd),
        .frse     (frse),
        .frte     (frte),
        .frtm     (frtm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] trs, input logic [1:0] trt,
                         input logic [4:0] a3, input logic we,
                         input logic [1:0] tnew);
        d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
        d_a3 = a3; d_we = we; d_tnew = tnew;
        #1;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, NONE, NONE, 5'd0, 1'b0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; md_busy = 1'b0; d_is_md = 1'b0;
        nop();
        repeat (2) tick();
        reset = 1'b0;

        // fill E/M with $8 writers, then reset with a writer still driven
        drive(5'd0, 5'd0, NONE, NONE, 5'd8, 1'b1, 2'd0); tick();
        drive(5'd0, 5'd0, NONE, NONE, 5'd8, 1'b1, 2'd0); tick();
        reset = 1'b1;
        drive(5'd8, 5'd8, 2'd0, 2'd0, 5'd8, 1'b1, 2'd0);
        repeat (2) tick();
        reset = 1'b0;
        drive(5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        check("rst_stall", {3'd0, stall}, 4'd0);
        check("rst_frsd", {1'b0, frsd}, 4'd0);
        check("rst_frtd", {1'b0, frtd}, 4'd0);
        check("rst_frse", {1'b0, frse}, 4'd0);
        check("rst_frte", {1'b0, frte}, 4'd0);
        check("rst_frtm", {1'b0, frtm}, 4'd0);
        tick();
        flush();

        // ALU result consumed by a branch in D
        drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 1'b1, 2'd1); tick();
        drive(5'd8, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        check("alu_stall1", {3'd0, stall}, 4'd1);
        check("alu_frsd_e", {1'b0, frsd}, 4'd0);
        tick();
        check("alu_stall2", {3'd0, stall}, 4'd0);
        check("alu_frsd_m", {1'b0, frsd}, 4'd2);
        tick();
        nop();
        check("alu_frse_w", {1'b0, frse}, 4'd2);
        tick();
        flush();

        // load-use through rt
        drive(5'd3, 5'd0, 2'd1, NONE, 5'd9, 1'b1, 2'd2); tick();
        drive(5'd4, 5'd9, 2'd1, 2'd1, 5'd11, 1'b1, 2'd1);
        check("ld_stall1", {3'd0, stall}, 4'd1);
        tick();
        check("ld_stall2", {3'd0, stall}, 4'd0);
        check("ld_frtd", {1'b0, frtd}, 4'd0);
        tick();
        nop();
        check("ld_frte_w", {1'b0, frte}, 4'd2);
        check("ld_frse", {1'b0, frse}, 4'd0);
        tick();
        flush();

        // store data comes late enough to need no stall
        drive(5'd3, 5'd0, 2'd1, NONE, 5'd10, 1'b1, 2'd2); tick();
        drive(5'd3, 5'd10, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);
        check("st_stall", {3'd0, stall}, 4'd0);
        check("st_frtd", {1'b0, frtd}, 4'd0);
        tick();
        nop();
        check("st_frte", {1'b0, frte}, 4'd0);
        tick();
        check("st_frtm", {1'b0, frtm}, 4'd1);
        tick();
        flush();

        // load two ahead of a branch: stall on M, then forward from W
        drive(5'd0, 5'd0, NONE, NONE, 5'd12, 1'b1, 2'd2); tick();
        nop(); tick();
        drive(5'd12, 5'd0, 2'd0, NONE, 5'd0, 1'b0, 2'd0);
        check("m_stall", {3'd0, stall}, 4'd1);
        tick();
        check("m_stall_end", {3'd0, stall}, 4'd0);
        check("m_frsd_w", {1'b0, frsd}, 4'd3);
        tick();
        flush();

        // two writers of $5: youngest wins
        drive(5'd0, 5'd0, NONE, NONE, 5'd5, 1'b1, 2'd0); tick();
        drive(5'd0, 5'd0, NONE, NONE, 5'd5, 1'b1, 2'd0); tick();
        drive(5'd5, 5'd5, 2'd1, 2'd1, 5'd0, 1'b0, 2'd0);
        check("pri_stall", {3'd0, stall}, 4'd0);
        check("pri_frsd", {1'b0, frsd}, 4'd1);
        check("pri_frtd", {1'b0, frtd}, 4'd1);
        tick();
        nop();
        check("pri_frse", {1'b0, frse}, 4'd1);
        check("pri_frte", {1'b0, frte}, 4'd1);
        tick();
        check("pri_frtm", {1'b0, frtm}, 4'd1);
        tick();
        flush();

        // same with $0: nothing may match
        drive(5'd0, 5'd0, NONE, NONE, 5'd0, 1'b1, 2'd2); tick();
        drive(5'd0, 5'd0, NONE, NONE, 5'd0, 1'b1, 2'd2); tick();
        drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        check("z_stall", {3'd0, stall}, 4'd0);
        check("z_frsd", {1'b0, frsd}, 4'd0);
        check("z_frtd", {1'b0, frtd}, 4'd0);
        tick();
        nop();
        check("z_frse", {1'b0, frse}, 4'd0);
        check("z_frte", {1'b0, frte}, 4'd0);
        tick();
        check("z_frtm", {1'b0, frtm}, 4'd0);
        tick();
        flush();

        // operands marked unused never stall or forward
        drive(5'd0, 5'd0, NONE, NONE, 5'd6, 1'b1, 2'd0); tick();
        drive(5'd6, 5'd6, NONE, NONE, 5'd0, 1'b0, 2'd0);
        check("tn_frsd", {1'b0, frsd}, 4'd0);
        check("tn_frtd", {1'b0, frtd}, 4'd0);
        tick();
        drive(5'd0, 5'd0, NONE, NONE, 5'd7, 1'b1, 2'd2); tick();
        drive(5'd7, 5'd7, NONE, NONE, 5'd0, 1'b0, 2'd0);
        check("tn_stall", {3'd0, stall}, 4'd0);
        tick();
        flush();

`ifdef MDU_STALL_EN
        md_busy = 1'b1; d_is_md = 1'b1;
        drive(5'd0, 5'd0, NONE, NONE, 5'd8, 1'b1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            check("md_busy_stall", {3'd0, stall}, 4'd1);
            tick();
        end
        md_busy = 1'b0; #1;
        check("md_release", {3'd0, stall}, 4'd0);
        tick();
        md_busy = 1'b1; d_is_md = 1'b0;
        drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 1'b1, 2'd1);
        check("md_non_md", {3'd0, stall}, 4'd0);
        tick();
        md_busy = 1'b0;
        flush();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side counterpart of the stage forwarding muxes (D, E and M stage rs/rt selects): generates every forward-select code and the D-stage stall for the 5-stage pipeline.
- Tracks destination register, Tnew and source registers of instructions in E, M and W in internal shadow pipeline registers.
- Compares these against the decode-stage instruction's rs/rt and Tuse.
- Sits beside the datapath; the select codes drive the forwarding muxes directly.

Parameters:
- TUSE_NONE, 3, Tuse code meaning "operand not read"; suppresses stall and forward for that operand.

Ports:
- clk        input   1   system clock, rising edge
- reset      input   1   synchronous, active-high reset
- d_rs       input   5   rs field of instruction in D
- d_rt       input   5   rt field of instruction in D
- d_tuse_rs  input   2   cycles until D instruction needs rs (0..2, 3 = TUSE_NONE)
- d_tuse_rt  input   2   same for rt
- d_a3       input   5   destination register of instruction in D
- d_we       input   1   D instruction writes the register file
- d_tnew     input   2   cycles after entering E until result is valid (0..2)
- stall      output  1   freeze PC and the D register; bubble into E
- frsd       output  3   D rs select: 0 RF, 1 E, 2 M, 3 W
- frtd       output  3   D rt select: same encoding
- frse       output  3   E rs select: 0 own, 1 M, 2 W
- frte       output  3   E rt select: same encoding
- frtm       output  3   M rt select: 0 own D2_M, 1 W write-back data

Behaviour:
- Shadow state, each {a3[4:0], tnew[1:0]}: E, M, W. Also rs_E, rt_E, rt_M.
- Reset: all shadow fields cleared to 0 on the reset edge. All outputs are then 0: stall=0, all selects 0.
- Each clock edge, not reset, stall=0:
  - E <= {d_we ? d_a3 : 0, d_tnew}; rs_E <= d_rs; rt_E <= d_rt.
  - M <= E with tnew-1, saturating at 0; rt_M <= rt_E.
  - W <= M with tnew-1, saturating at 0.
- Each clock edge, not reset, stall=1:
  - E <= bubble: a3=0, tnew=0, rs_E=0, rt_E=0.
  - M and W advance exactly as in the stall=0 case.
- Register 0 never matches anything; a3=0 means "no write".
- Stall, combinational, evaluated per operand X in {rs, rt} with tuse != TUSE_NONE and d_X != 0:
  - Stall when (E.a3==d_X && E.tnew > tuse) or (M.a3==d_X && M.tnew > tuse).
  - stall = OR of both operands.
- Forward selects are combinational. A producer qualifies only when a3 matches, a3 != 0 and tnew == 0. Priority is the youngest stage.
  - frsd/frtd: E(1) > M(2) > W(3), else 0. Forced 0 when tuse == TUSE_NONE.
  - frse/frte: against rs_E/rt_E; M(1) > W(2), else 0.
  - frtm: against rt_M; W(1), else 0.
- A select is never nonzero for a producer with tnew > 0. Such a case is covered by stall, or the value is re-forwarded from a later stage.
- During stall, frsd/frtd are don't-care but still follow the rules above. E/M selects stay valid: the older instructions keep moving.
- Reset mid-stall: reset wins; the bubble state equals the reset state.
- No flush input. Branch delay slot handling is outside this block.

Optional Feature:
- Macro: MDU_STALL_EN.
- Defined: adds ports md_busy (input 1, multiply/divide unit busy or starting) and d_is_md (input 1, D instruction uses HI/LO or the MDU). stall additionally asserts when md_busy && d_is_md. Same bubble insertion applies.
- Undefined: ports absent; stall is derived from register hazards only.

Test Plan:
- Reset: assert reset 2 cycles with arbitrary inputs -> stall=0, all selects 0 in the cycle after release, before any new instruction is accepted.
- ALU to D via M: addu $8 (d_we=1, d_a3=8, d_tnew=1), then beq reading $8 (tuse_rs=0) -> 1 cycle stall=1. Next cycle frsd=2 (M) and stall=0.
- Load-use: lw $9 (tnew=2), then addu reading rt=$9 (tuse_rt=1) -> stall=1 for exactly 1 cycle. Then frte=2 (W) when the addu reaches E.
- Store data forward: lw $10, then sw with rt=$10 (tuse_rt=2) -> no stall. frtm=1 when sw is in M and lw is in W.
- Priority and $0: two consecutive writers of $5, then a reader -> frse=1 (M, the younger writer). Repeat with $0 -> all selects 0, stall 0.
- MDU_STALL_EN: md_busy=1 with mfhi in D -> stall held for the whole busy window. md_busy=1 with a non-MDU addu in D -> no stall.
